// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits sharing one decoder.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks zero digits above the top nonzero one).
module seg_scan_controller #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    blank_all,
    output logic [3:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [2:0]              digit_idx,
    output logic                    frame_done,
    output logic                    upd_pending
);

    localparam int unsigned         ValW    = 4 * NUM_DIGITS;
    localparam logic [DIV_W-1:0]    DivLast = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]          IdxLast = 3'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      presc_q, presc_d;
    logic [2:0]            idx_q, idx_d;
    logic [ValW-1:0]       shadow_q, shadow_d;
    logic [ValW-1:0]       disp_q, disp_d;
    logic                  pend_q, pend_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]            code_q, code_d;
    logic                  frame_done_q, frame_done_d;

    logic tick;
    logic wrap;

    assign tick = (presc_q == DivLast);
    assign wrap = tick && (idx_q == IdxLast);

    always_comb begin
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        if (tick) begin
            idx_d = wrap ? 3'd0 : idx_q + 3'd1;
        end
        frame_done_d = wrap;

        shadow_d = shadow_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        // A load coinciding with the wrap bypasses the shadow so it is not delayed a frame.
        if (load && wrap) begin
            shadow_d = value_in;
            disp_d   = value_in;
            pend_d   = 1'b0;
        end else begin
            if (wrap && pend_q) begin
                disp_d = shadow_q;
                pend_d = 1'b0;
            end
            if (load) begin
                shadow_d = value_in;
                pend_d   = 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  nz_seen;

    always_comb begin
        lead_zero = '0;
        nz_seen   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (disp_q[4*i +: 4] != 4'h0) begin
                nz_seen = 1'b1;
            end
            lead_zero[i] = !nz_seen && (i != 0);
        end
    end
`endif

    always_comb begin
        an_d   = '1;
        code_d = 4'hF;
        if (!blank_all) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_q != 3'(i));
                if (idx_q == 3'(i)) begin
`ifdef LEADING_ZERO_BLANK_EN
                    code_d = lead_zero[i] ? 4'hF : disp_q[4*i +: 4];
`else
                    code_d = disp_q[4*i +: 4];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            disp_q       <= '0;
            pend_q       <= 1'b0;
            an_q         <= '1;
            code_q       <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            an_q         <= an_d;
            code_q       <= code_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_code  = code_q;
    assign an_n        = an_q;
    assign digit_idx   = idx_q;
    assign frame_done  = frame_done_q;
    assign upd_pending = pend_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with NUM_DIGITS=4, SCAN_DIV=3.
module tb_seg_scan_controller;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 3;
    localparam int unsigned DW = 2;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          load      = 1'b0;
    logic          blank_all = 1'b0;
    logic [15:0]   value_in  = 16'h0;
    logic [3:0]    digit_code;
    logic [ND-1:0] an_n;
    logic [2:0]    digit_idx;
    logic          frame_done;
    logic          upd_pending;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [15:0] ExpZero = 16'hFFF0;
    localparam logic [15:0] Exp0045 = 16'hFF45;
`else
    localparam logic [15:0] ExpZero = 16'h0000;
    localparam logic [15:0] Exp0045 = 16'h0045;
`endif

    seg_scan_controller #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SD),
        .DIV_W     (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value_in   (value_in),
        .blank_all  (blank_all),
        .digit_code (digit_code),
        .an_n       (an_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done),
        .upd_pending(upd_pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one 12-cycle frame; exp_codes holds the code expected in each slot (nibble 0 = slot 0).
    task automatic run_frame(input string tag, input logic [15:0] exp_codes, input int load_at,
                             input logic [15:0] load_val);
        logic [15:0] an_tbl;
        int          slot;
        an_tbl = 16'b0111_1011_1101_1110;
        for (int n = 0; n < 12; n++) begin
            slot = n / 3;
            if (n == load_at) begin
                load     = 1'b1;
                value_in = load_val;
            end
            step();
            load = 1'b0;
            check_eq({tag, "_an"}, 32'(an_n), 32'(an_tbl[4*slot +: 4]));
            check_eq({tag, "_code"}, 32'(digit_code), 32'(exp_codes[4*slot +: 4]));
            check_eq({tag, "_idx"}, 32'(digit_idx), 32'(((n + 1) / 3) % 4));
            check_eq({tag, "_fdone"}, 32'(frame_done), 32'(n == 11));
            if (n == load_at) begin
                check_eq({tag, "_pend_load"}, 32'(upd_pending), 32'(n != 11));
            end
        end
        check_eq({tag, "_pend_end"}, 32'(upd_pending), 32'd0);
    endtask

    initial begin
        // Async reset: outputs take reset values before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_eq("rst_async_an", 32'(an_n), 32'hF);
        check_eq("rst_async_code", 32'(digit_code), 32'hF);
        check_eq("rst_async_fdone", 32'(frame_done), 32'd0);
        check_eq("rst_async_pend", 32'(upd_pending), 32'd0);
        check_eq("rst_async_idx", 32'(digit_idx), 32'd0);
        repeat (5) step();
        rst = 1'b0;

        run_frame("f1", ExpZero, 0, 16'h1234);
        run_frame("f2", 16'h1234, 4, 16'h5678);
        run_frame("f3", 16'h5678, -1, 16'h0);
        run_frame("f4", 16'h5678, 11, 16'hABCD);
        run_frame("f5", 16'hABCD, -1, 16'h0);

        blank_all = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            check_eq("blank_an", 32'(an_n), 32'hF);
            check_eq("blank_code", 32'(digit_code), 32'hF);
            check_eq("blank_fdone", 32'(frame_done), 32'(n == 11));
        end
        check_eq("blank_idx", 32'(digit_idx), 32'd2);
        blank_all = 1'b0;
        step();
        check_eq("unblank_an2", 32'(an_n), 32'b1011);
        check_eq("unblank_code2", 32'(digit_code), 32'hB);
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq("unblank_an3", 32'(an_n), 32'b0111);
            check_eq("unblank_code3", 32'(digit_code), 32'hA);
            check_eq("unblank_fdone", 32'(frame_done), 32'(n == 2));
        end
        run_frame("f8", 16'hABCD, -1, 16'h0);

        // Mid-frame reset with an update still pending.
        step();
        load     = 1'b1;
        value_in = 16'h9999;
        step();
        load = 1'b0;
        check_eq("pre_rst_pend", 32'(upd_pending), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_an", 32'(an_n), 32'hF);
        check_eq("mid_rst_code", 32'(digit_code), 32'hF);
        check_eq("mid_rst_pend", 32'(upd_pending), 32'd0);
        check_eq("mid_rst_idx", 32'(digit_idx), 32'd0);
        repeat (5) step();
        check_eq("mid_rst_hold_an", 32'(an_n), 32'hF);
        rst = 1'b0;

        run_frame("r1", ExpZero, 0, 16'h0045);
        run_frame("r2", Exp0045, 3, 16'h0000);
        run_frame("r3", ExpZero, 3, 16'h1004);
        run_frame("r4", 16'h1004, -1, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
